// File: rtl/mux_pkg.sv
// Shared definitions for the parametrised selector family: mode encodings and
// the select-width helper.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // A single-channel mux would give $clog2(1)=0; keep at least one index bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester found scanning upward from
// ptr+1, wrapping modulo CHANNELS. The pointer itself is owned by the caller.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = sel_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic                grant_valid,
  output logic [SEL_W-1:0]    grant_idx
);

  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = (int'(ptr) + k) % CHANNELS;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/muxn_rr.sv
// N-channel selector with fixed or round-robin grant, valid/ready handshakes on
// every channel and a one-entry registered output stage.
module muxn_rr
  import mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             can_load;
  logic             rr_gv, fix_gv, gv;
  logic [SEL_W-1:0] rr_idx, gidx;
  logic [WIDTH-1:0] gdata;
  logic             xfer;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arb (
    .req         (in_valid),
    .ptr         (ptr_q),
    .grant_valid (rr_gv),
    .grant_idx   (rr_idx)
  );

  // Matching select against each legal index means an out-of-range select never grants.
  always_comb begin
    fix_gv = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (select == SEL_W'(i) && in_valid[i]) fix_gv = 1'b1;
    end
  end

  assign can_load = !out_valid_q || out_ready;
  assign gv       = (mode == MODE_RR) ? rr_gv  : fix_gv;
  assign gidx     = (mode == MODE_RR) ? rr_idx : select;
  assign xfer     = gv && can_load;

  always_comb begin
    in_ready = '0;
    gdata    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gidx == SEL_W'(i)) begin
        in_ready[i] = xfer;
        gdata       = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = gdata;
      out_chan_d  = gidx;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) ptr_d = gidx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pointer resets to the last channel so channel 0 wins the first RR scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SEL_W'(CHANNELS - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_muxn_rr.sv
// Directed bench for muxn_rr: a 4-channel instance for the main scenarios and a
// 3-channel instance for the out-of-range fixed select.
module tb_muxn_rr;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [127:0] in_data4;
  logic [3:0]   in_valid4, in_ready4;
  logic         mode4, out_valid4, out_ready4;
  logic [1:0]   select4, out_chan4;
  logic [31:0]  out_data4;

  logic [95:0]  in_data3;
  logic [2:0]   in_valid3, in_ready3;
  logic         mode3, out_valid3, out_ready3;
  logic [1:0]   select3, out_chan3;
  logic [31:0]  out_data3;

  int n_cmp = 0;
  int n_err = 0;

  muxn_rr #(.WIDTH(32), .CHANNELS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .mode(mode4), .select(select4), .out_data(out_data4),
    .out_chan(out_chan4), .out_valid(out_valid4), .out_ready(out_ready4)
  );

  muxn_rr #(.WIDTH(32), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(mode3), .select(select3), .out_data(out_data3),
    .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  logic [31:0] vals [4] = '{32'hdeadbeef, 32'hbeefdead, 32'h0000beef, 32'hdead0000};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_data4 = {vals[3], vals[2], vals[1], vals[0]};
    in_valid4 = '0; mode4 = 1'b0; select4 = '0; out_ready4 = 1'b1;
    in_data3 = {32'h33333333, 32'h22222222, 32'h11111111};
    in_valid3 = '0; mode3 = 1'b0; select3 = '0; out_ready3 = 1'b1;
    tick(); tick();
    n_cmp++; if (out_valid4 !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid4); end
    n_cmp++; if (out_data4 !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", out_data4); end
    n_cmp++; if (out_chan4 !== 2'd0) begin n_err++; $display("FAIL reset_chan got %0d want 0", out_chan4); end
    n_cmp++; if (out_valid3 !== 1'b0) begin n_err++; $display("FAIL reset_valid3 got %b want 0", out_valid3); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fixed();
    mode4 = 1'b0; select4 = 2'd2; in_valid4 = 4'b0100; out_ready4 = 1'b1;
    #1;
    n_cmp++; if (in_ready4 !== 4'b0100) begin n_err++; $display("FAIL fixed_in_ready got %b want 0100", in_ready4); end
    tick();
    n_cmp++; if (out_data4 !== 32'h0000beef) begin n_err++; $display("FAIL fixed_data got %h want 0000beef", out_data4); end
    n_cmp++; if (out_chan4 !== 2'd2) begin n_err++; $display("FAIL fixed_chan got %0d want 2", out_chan4); end
    n_cmp++; if (out_valid4 !== 1'b1) begin n_err++; $display("FAIL fixed_valid got %b want 1", out_valid4); end
    in_valid4 = 4'b0000;
    tick();
    n_cmp++; if (out_valid4 !== 1'b0) begin n_err++; $display("FAIL fixed_drain got %b want 0", out_valid4); end
    n_cmp++; if (out_data4 !== 32'h0000beef) begin n_err++; $display("FAIL fixed_hold got %h want 0000beef", out_data4); end
  endtask

  // ptr is still at reset value 3 (fixed mode leaves it alone): grants start at 0.
  task automatic test_rr_rotation();
    mode4 = 1'b1; in_valid4 = 4'b1111; out_ready4 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [3:0] exp_rdy;
      exp_rdy = 4'b0001 << (k % 4);
      #1;
      n_cmp++; if (in_ready4 !== exp_rdy) begin n_err++; $display("FAIL rr_in_ready[%0d] got %b want %b", k, in_ready4, exp_rdy); end
      tick();
      n_cmp++; if (out_chan4 !== 2'(k % 4)) begin n_err++; $display("FAIL rr_chan[%0d] got %0d want %0d", k, out_chan4, k % 4); end
      n_cmp++; if (out_data4 !== vals[k % 4]) begin n_err++; $display("FAIL rr_data[%0d] got %h want %h", k, out_data4, vals[k % 4]); end
      n_cmp++; if (out_valid4 !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d] got %b want 1", k, out_valid4); end
    end
    in_valid4 = 4'b0000;
    tick();
  endtask

  // ptr is 1 here, so the first grant is channel 2.
  task automatic test_backpressure();
    in_valid4 = 4'b1111; out_ready4 = 1'b1;
    tick();
    n_cmp++; if (out_chan4 !== 2'd2) begin n_err++; $display("FAIL bp_first_chan got %0d want 2", out_chan4); end
    out_ready4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (in_ready4 !== 4'b0000) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b want 0000", k, in_ready4); end
      tick();
      n_cmp++; if (out_chan4 !== 2'd2 || out_data4 !== 32'h0000beef || out_valid4 !== 1'b1) begin
        n_err++; $display("FAIL bp_frozen[%0d] got chan %0d data %h valid %b want 2 0000beef 1", k, out_chan4, out_data4, out_valid4);
      end
    end
    out_ready4 = 1'b1;
    #1;
    n_cmp++; if (in_ready4 !== 4'b1000) begin n_err++; $display("FAIL bp_resume_ready got %b want 1000", in_ready4); end
    tick();
    n_cmp++; if (out_chan4 !== 2'd3 || out_data4 !== 32'hdead0000) begin
      n_err++; $display("FAIL bp_resume got chan %0d data %h want 3 dead0000", out_chan4, out_data4);
    end
    in_valid4 = 4'b0000;
    tick();
  endtask

  task automatic test_sparse();
    logic [1:0] exp_ch [3] = '{2'd3, 2'd0, 2'd3};
    in_valid4 = 4'b0001;
    tick();
    in_valid4 = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      logic [3:0] exp_rdy;
      exp_rdy = 4'b0001 << exp_ch[k];
      #1;
      n_cmp++; if (in_ready4 !== exp_rdy) begin n_err++; $display("FAIL sparse_in_ready[%0d] got %b want %b", k, in_ready4, exp_rdy); end
      tick();
      n_cmp++; if (out_chan4 !== exp_ch[k]) begin n_err++; $display("FAIL sparse_chan[%0d] got %0d want %0d", k, out_chan4, exp_ch[k]); end
    end
    in_valid4 = 4'b0000;
    tick();
  endtask

  task automatic test_out_of_range();
    mode3 = 1'b0; select3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    #1;
    n_cmp++; if (in_ready3 !== 3'b000) begin n_err++; $display("FAIL oor_in_ready got %b want 000", in_ready3); end
    tick();
    n_cmp++; if (out_valid3 !== 1'b0) begin n_err++; $display("FAIL oor_valid got %b want 0", out_valid3); end
    select3 = 2'd1;
    #1;
    n_cmp++; if (in_ready3 !== 3'b010) begin n_err++; $display("FAIL inrange_in_ready got %b want 010", in_ready3); end
    tick();
    n_cmp++; if (out_chan3 !== 2'd1 || out_data3 !== 32'h22222222) begin
      n_err++; $display("FAIL inrange_out got chan %0d data %h want 1 22222222", out_chan3, out_data3);
    end
    in_valid3 = 3'b000;
    tick();
  endtask

  // Pre-reset grant to channel 1 leaves ptr=1; after reset, 0110 must grant 1, not 2.
  task automatic test_reset_mid();
    mode4 = 1'b1; in_valid4 = 4'b0010; out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0; in_valid4 = 4'b0110;
    n_cmp++; if (out_valid4 !== 1'b1 || out_chan4 !== 2'd1) begin
      n_err++; $display("FAIL mid_pre got valid %b chan %0d want 1 1", out_valid4, out_chan4);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid4 !== 1'b0) begin n_err++; $display("FAIL mid_async_valid got %b want 0", out_valid4); end
    n_cmp++; if (out_data4 !== 32'h0 || out_chan4 !== 2'd0) begin
      n_err++; $display("FAIL mid_async_regs got data %h chan %0d want 0 0", out_data4, out_chan4);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready4 = 1'b1;
    #1;
    n_cmp++; if (in_ready4 !== 4'b0010) begin n_err++; $display("FAIL post_reset_ready got %b want 0010", in_ready4); end
    tick();
    n_cmp++; if (out_chan4 !== 2'd1 || out_valid4 !== 1'b1) begin
      n_err++; $display("FAIL post_reset_grant got chan %0d valid %b want 1 1", out_chan4, out_valid4);
    end
    in_valid4 = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_rotation();
    test_backpressure();
    test_sparse();
    test_out_of_range();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
